fifo_read_operation: RTL

- Read-side controller for the 8-entry synchronous FIFO register file.
- Owns the read pointer and the occupancy count. Selects one of the 8 register outputs, registers it onto dout, and returns read acknowledge and read error.
- Pairs with the write-side decoder/enable logic: it consumes that side's accepted-write pulse and feeds back full/empty so the write side can gate its enable.

---
 rtl/fifo_read_operation.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_read_operation.sv
// Read-side controller for the 8-entry FIFO register file: owns the read pointer and
// occupancy count, muxes the head entry onto a registered dout and reports ack/error/overflow.
module fifo_read_operation #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rd_en,
    input  logic                      wr_done,
    input  logic [8*DATA_WIDTH-1:0]   reg_data,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      rd_ack,
    output logic                      rd_err,
    output logic [2:0]                rd_addr,
    output logic [3:0]                data_count,
    output logic                      empty,
    output logic                      full,
    output logic                      ovf
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        RD_ERROR = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic [2:0]              r_rd_addr;
    logic [3:0]              r_count;
    logic                    r_ovf;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_rd_acc;
    logic [DATA_WIDTH-1:0]   w_head;

    assign w_empty  = (r_count == 4'd0);
    assign w_full   = (r_count == 4'd8);
    assign w_rd_acc = rd_en & ~w_empty;

    // Head-entry mux driven only by the registered pointer.
    always_comb begin
        w_head = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (r_rd_addr == k[2:0]) begin
                w_head = reg_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (rd_en) begin
            w_next_state = w_empty ? RD_ERROR : READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout    <= '0;
            r_rd_addr <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_dout    <= w_head;
                r_rd_addr <= r_rd_addr + 3'd1;
            end
            unique case ({wr_done, w_rd_acc})
                2'b10: begin
                    if (!w_full) begin
                        r_count <= r_count + 4'd1;
                    end
                end
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            // A write arriving while full with no read to make room is dropped.
            r_ovf <= wr_done & ~w_rd_acc & w_full;
        end
    end

    assign dout       = r_dout;
    assign rd_ack     = (r_state == READ);
    assign rd_err     = (r_state == RD_ERROR);
    assign rd_addr    = r_rd_addr;
    assign data_count = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign ovf        = r_ovf;

endmodule
